// File: rtl/ibex_prefetch_buffer_mq_pkg.sv
// Shared widths, request FSM encoding and address helpers for the multi-request prefetch buffer.
package ibex_prefetch_buffer_mq_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_e;

    function automatic logic [OBI_ADDR_W-1:0] word_align(input logic [OBI_ADDR_W-1:0] a);
        return {a[OBI_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_prefetch_buffer_mq_if.sv
// OBI instruction-fetch bus between the prefetcher (master) and memory/PMP (slave).
interface ibex_prefetch_buffer_mq_if;
    import ibex_prefetch_buffer_mq_pkg::*;

    // Request phase: instr_req is held with instr_addr stable until instr_gnt or instr_pmp_err is
    // seen on a rising edge; response phase: one instr_rvalid per granted (non-PMP) request, in order.
    logic                  instr_req;
    logic                  instr_gnt;
    logic [OBI_ADDR_W-1:0] instr_addr;
    logic [OBI_DATA_W-1:0] instr_rdata;
    logic                  instr_err;
    logic                  instr_pmp_err;
    logic                  instr_rvalid;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rdata, instr_err, instr_pmp_err, instr_rvalid
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rdata, instr_err, instr_pmp_err, instr_rvalid
    );

endinterface

// File: rtl/ibex_prefetch_buffer_mq_fifo.sv
// Shift-register fetch FIFO; tracks the address of its head word, restarting at clear_addr_i.
module ibex_fetch_fifo_mq
    import ibex_prefetch_buffer_mq_pkg::*;
#(
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [OBI_ADDR_W-1:0] clear_addr_i,
    input  logic                  in_valid_i,
    input  logic [OBI_DATA_W-1:0] in_rdata_i,
    input  logic                  in_err_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OBI_DATA_W-1:0] out_rdata_o,
    output logic [OBI_ADDR_W-1:0] out_addr_o,
    output logic                  out_err_o,
    output logic [CNT_W-1:0]      level_o
);

    logic [CNT_W-1:0]      r_level;
    logic [OBI_DATA_W-1:0] r_rdata [DEPTH];
    logic [DEPTH-1:0]      r_err;
    logic [OBI_ADDR_W-1:0] r_addr;
    logic                  w_pop;
    logic                  w_push;
    logic [CNT_W-1:0]      w_widx;

    assign out_valid_o = (r_level != '0);
    assign w_pop       = out_valid_o & out_ready_i & ~clear_i;
    // Pop happens first, so a full FIFO can still accept a word in the cycle it is read.
    assign w_push      = in_valid_i & ~clear_i & ((r_level < CNT_W'(DEPTH)) | w_pop);
    assign w_widx      = r_level - CNT_W'(w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= '0;
        end else if (clear_i) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (w_pop) begin
                r_rdata[i] <= r_rdata[i+1];
                r_err[i]   <= r_err[i+1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_push && (w_widx == CNT_W'(i))) begin
                r_rdata[i] <= in_rdata_i;
                r_err[i]   <= in_err_i;
            end
        end
    end

    // The first word after a redirect may start at a halfword; every later one is word aligned.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            r_addr <= clear_addr_i;
        end else if (w_pop) begin
            r_addr <= word_align(r_addr) + 32'd4;
        end
    end

    assign out_rdata_o = r_rdata[0];
    assign out_err_o   = r_err[0];
    assign out_addr_o  = r_addr;
    assign level_o     = r_level;

endmodule

// File: rtl/ibex_prefetch_buffer_mq.sv
// Instruction prefetcher: up to NUM_REQS OBI fetches in flight, credit-limited so responses never
// overflow the FIFO_DEPTH fetch FIFO; branch_i flushes and redirects.
module ibex_prefetch_buffer_mq
    import ibex_prefetch_buffer_mq_pkg::*;
#(
    parameter  int unsigned NUM_REQS   = 2,
    parameter  int unsigned FIFO_DEPTH = 3,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [OBI_ADDR_W-1:0] addr_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [OBI_DATA_W-1:0] rdata_o,
    output logic [OBI_ADDR_W-1:0] addr_o,
    output logic                  err_o,
    ibex_prefetch_buffer_mq_if.master bus,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic [CNT_W-1:0]      fifo_level_o
);

    localparam int unsigned SUM_W = CNT_W + 1;

    req_state_e            r_state, w_state_nxt;
    logic [NUM_REQS-1:0]   r_out, r_disc, r_pmp;
    logic [NUM_REQS-1:0]   w_out_sh, w_disc_sh, w_pmp_sh, w_fill;
    logic [OBI_ADDR_W-1:0] r_fetch_addr, r_stored_addr, w_req_addr;
    logic                  r_wait_disc;
    logic                  w_gnt_any, w_resp, w_push, w_new_req, w_issue, w_gnt_disc, w_credit;
    logic [CNT_W-1:0]      w_out_cnt, w_live_cnt, w_fifo_level;
    logic [SUM_W-1:0]      w_sum;

    always_comb begin
        w_out_cnt  = '0;
        w_live_cnt = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            w_out_cnt  = w_out_cnt + CNT_W'(r_out[i]);
            w_live_cnt = w_live_cnt + CNT_W'(r_out[i] & ~r_disc[i]);
        end
    end

    // Discarded slots return no word, so only live ones consume FIFO credit.
    assign w_sum     = SUM_W'(w_fifo_level) + SUM_W'(w_live_cnt);
    assign w_credit  = w_sum < SUM_W'(FIFO_DEPTH);
    assign w_new_req = req_i & fetch_en_i & ~r_out[NUM_REQS-1] & (w_credit | branch_i);
    assign w_issue   = (r_state == REQ_IDLE) & w_new_req;

    always_comb begin
        w_state_nxt   = r_state;
        bus.instr_req = 1'b0;
        unique case (r_state)
            REQ_IDLE: begin
                bus.instr_req = w_new_req;
                if (w_new_req && !(bus.instr_gnt || bus.instr_pmp_err)) w_state_nxt = REQ_WAIT;
            end
            REQ_WAIT: begin
                bus.instr_req = 1'b1;
                if (bus.instr_gnt || bus.instr_pmp_err) w_state_nxt = REQ_IDLE;
            end
        endcase
    end

    assign w_req_addr     = (r_state == REQ_WAIT) ? r_stored_addr : (branch_i ? addr_i : r_fetch_addr);
    assign bus.instr_addr = word_align(w_req_addr);
    assign w_gnt_any      = bus.instr_req & (bus.instr_gnt | bus.instr_pmp_err);
    assign w_gnt_disc     = (r_state == REQ_WAIT) & (branch_i | r_wait_disc);

    // A PMP-blocked slot gets no bus response and retires as soon as it reaches slot 0.
    assign w_resp    = r_out[0] & (bus.instr_rvalid | r_pmp[0]);
    assign w_out_sh  = w_resp ? (r_out >> 1)  : r_out;
    assign w_disc_sh = w_resp ? (r_disc >> 1) : r_disc;
    assign w_pmp_sh  = w_resp ? (r_pmp >> 1)  : r_pmp;

    always_comb begin
        w_fill    = '0;
        w_fill[0] = w_gnt_any & ~w_out_sh[0];
        for (int i = 1; i < int'(NUM_REQS); i++) begin
            w_fill[i] = w_gnt_any & ~w_out_sh[i] & w_out_sh[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= REQ_IDLE;
            r_out       <= '0;
            r_disc      <= '0;
            r_pmp       <= '0;
            r_wait_disc <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_sh | w_fill;
            r_disc      <= (branch_i ? w_out_sh : w_disc_sh) | (w_fill & {NUM_REQS{w_gnt_disc}});
            r_pmp       <= w_pmp_sh | (w_fill & {NUM_REQS{bus.instr_pmp_err}});
            r_wait_disc <= (r_state == REQ_WAIT) & ~w_gnt_any & (r_wait_disc | branch_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue && !w_gnt_any) r_stored_addr <= w_req_addr;
        if (branch_i || w_issue) begin
            r_fetch_addr <= (branch_i ? addr_i : word_align(r_fetch_addr)) + (w_issue ? 32'd4 : 32'd0);
        end
    end

    // A redirect in the same cycle as a response drops that word.
    assign w_push = w_resp & ~r_disc[0] & ~branch_i;

    ibex_fetch_fifo_mq #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (branch_i),
        .clear_addr_i (addr_i),
        .in_valid_i   (w_push),
        .in_rdata_i   (bus.instr_rdata),
        .in_err_i     ((bus.instr_err & bus.instr_rvalid) | r_pmp[0]),
        .out_valid_o  (valid_o),
        .out_ready_i  (ready_i),
        .out_rdata_o  (rdata_o),
        .out_addr_o   (addr_o),
        .out_err_o    (err_o),
        .level_o      (w_fifo_level)
    );

    assign fifo_level_o  = w_fifo_level;
    assign outstanding_o = w_out_cnt;
    assign busy_o        = bus.instr_req | (|r_out);

endmodule
